// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolution slice: widths, FSM states and
// the per-stage prediction record carried from D to E.
package bp_pkg;
   localparam int PC_W   = 8;
   localparam int CNT_W  = 16;
   localparam int PC_INC = 4;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } bp_state_e;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic            ptaken;
      logic [PC_W-1:0] ptarget;
   } bp_stage_t;
endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module bp_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/branch_resolve_unit.sv
// Carries fetch predictions through D and E, resolves them at E, drives the
// predictor update strobes and holds a redirect request to fetch on mispredict.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | pipeline advancing; branches/jumps in E are resolved
//   REDIRECT | redirect_pc offered to fetch; D/E frozen and squashed
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int STAT_W = bp_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_F,
   input  logic [PC_W-1:0]   pc_F,
   input  logic [1:0]        predict_F,
   input  logic [PC_W-1:0]   ptarget_F,
   input  logic              stall,
   input  logic              branch_E,
   input  logic              jump_E,
   input  logic              take_E,
   input  logic [PC_W-1:0]   target_E,
   input  logic              redirect_ready,
   output logic              redirect_valid,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              flush_D,
   output logic              flush_E,
   output logic              upd_branch,
   output logic              upd_jump,
   output logic              upd_take,
   output logic [PC_W-1:0]   upd_pc,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

   bp_state_e       state_q;
   bp_stage_t       d_q, e_q, f_stage;
   logic [PC_W-1:0] rpc_q;
   logic            idle, resolvable, act_taken, mispredict, redo;
   logic [PC_W-1:0] correct_pc;
   logic            unused_pred_lsb;

   // Only the direction bit of the 2-bit counter is needed downstream.
   assign unused_pred_lsb = predict_F[0];

   always_comb begin
      f_stage         = '0;
      f_stage.valid   = valid_F;
      f_stage.pc      = pc_F;
      f_stage.ptaken  = predict_F[1];
      f_stage.ptarget = ptarget_F;
   end

   always_comb begin
      idle       = (state_q == IDLE);
      resolvable = e_q.valid & ~stall & idle & (branch_E | jump_E);
      act_taken  = jump_E | take_E;
      mispredict = (act_taken != e_q.ptaken) |
                   (act_taken & e_q.ptaken & (target_E != e_q.ptarget));
      correct_pc = act_taken ? target_E : e_q.pc + PC_STEP;
      redo       = resolvable & mispredict;
   end

   assign upd_branch     = resolvable & branch_E & ~jump_E;
   assign upd_jump       = resolvable & jump_E;
   assign upd_take       = jump_E | take_E;
   assign upd_pc         = e_q.pc;
   assign redirect_valid = (state_q == REDIRECT);
   assign redirect_pc    = rpc_q;
   assign flush_D        = (state_q == REDIRECT);
   assign flush_E        = (state_q == REDIRECT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         d_q     <= '0;
         e_q     <= '0;
         rpc_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!stall) begin
                  d_q <= f_stage;
                  e_q <= d_q;
                  // Wrong-path instructions behind the mispredict are squashed.
                  if (redo) begin
                     d_q.valid <= 1'b0;
                     e_q.valid <= 1'b0;
                     rpc_q     <= correct_pc;
                     state_q   <= REDIRECT;
                  end
               end
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   bp_sat_counter #(.W(STAT_W)) u_branch_cnt (
      .clk (clk),
      .rst (rst),
      .en  (resolvable),
      .cnt (branch_cnt)
   );

   bp_sat_counter #(.W(STAT_W)) u_mispred_cnt (
      .clk (clk),
      .rst (rst),
      .en  (redo),
      .cnt (mispred_cnt)
   );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, redirect handshake and
// reset-abort sequences, then random traffic against a reference model.
module tb_branch_resolve_unit;
   import bp_pkg::*;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            valid_F, stall, branch_E, jump_E, take_E, redirect_ready;
   logic [PC_W-1:0] pc_F, ptarget_F, target_E;
   logic [1:0]      predict_F;

   logic            redirect_valid, flush_D, flush_E, upd_branch, upd_jump, upd_take;
   logic [PC_W-1:0] redirect_pc, upd_pc;
   logic [15:0]     branch_cnt, mispred_cnt;

   logic            s_redirect_valid, s_flush_D, s_flush_E, s_upd_branch, s_upd_jump, s_upd_take;
   logic [PC_W-1:0] s_redirect_pc, s_upd_pc;
   logic [3:0]      s_branch_cnt, s_mispred_cnt;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk(clk), .rst(rst), .valid_F(valid_F), .pc_F(pc_F), .predict_F(predict_F),
      .ptarget_F(ptarget_F), .stall(stall), .branch_E(branch_E), .jump_E(jump_E),
      .take_E(take_E), .target_E(target_E), .redirect_ready(redirect_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_D(flush_D),
      .flush_E(flush_E), .upd_branch(upd_branch), .upd_jump(upd_jump),
      .upd_take(upd_take), .upd_pc(upd_pc), .branch_cnt(branch_cnt),
      .mispred_cnt(mispred_cnt)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   branch_resolve_unit #(.STAT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .valid_F(valid_F), .pc_F(pc_F), .predict_F(predict_F),
      .ptarget_F(ptarget_F), .stall(stall), .branch_E(branch_E), .jump_E(jump_E),
      .take_E(take_E), .target_E(target_E), .redirect_ready(redirect_ready),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush_D(s_flush_D),
      .flush_E(s_flush_E), .upd_branch(s_upd_branch), .upd_jump(s_upd_jump),
      .upd_take(s_upd_take), .upd_pc(s_upd_pc), .branch_cnt(s_branch_cnt),
      .mispred_cnt(s_mispred_cnt)
   );

   // ---------------- reference model ----------------
   logic            m_vD, m_ptD, m_vE, m_ptE, m_redir;
   logic [PC_W-1:0] m_pcD, m_ptgD, m_pcE, m_ptgE, m_rpc;
   int              m_bcnt, m_mcnt;
   logic            m_at, m_res, m_misp;
   logic [PC_W-1:0] m_cpc;

   always_comb begin
      m_at   = jump_E | take_E;
      m_res  = !m_redir && !stall && m_vE && (branch_E || jump_E);
      m_misp = (m_at != m_ptE) || (m_at && m_ptE && (target_E != m_ptgE));
      m_cpc  = m_at ? target_E : PC_W'(int'(m_pcE) + PC_INC);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vD <= 0; m_ptD <= 0; m_pcD <= 0; m_ptgD <= 0;
         m_vE <= 0; m_ptE <= 0; m_pcE <= 0; m_ptgE <= 0;
         m_redir <= 0; m_rpc <= 0; m_bcnt <= 0; m_mcnt <= 0;
      end else if (m_redir) begin
         if (redirect_ready) m_redir <= 0;
      end else if (!stall) begin
         m_vD <= valid_F; m_pcD <= pc_F; m_ptD <= predict_F[1]; m_ptgD <= ptarget_F;
         m_vE <= m_vD;    m_pcE <= m_pcD; m_ptE <= m_ptD;       m_ptgE <= m_ptgD;
         if (m_res) m_bcnt <= m_bcnt + 1;
         if (m_res && m_misp) begin
            m_redir <= 1;
            m_rpc   <= m_cpc;
            m_mcnt  <= m_mcnt + 1;
            m_vD    <= 0;
            m_vE    <= 0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic idle_inputs();
      valid_F = 0; pc_F = 0; predict_F = 0; ptarget_F = 0; stall = 0;
      branch_E = 0; jump_E = 0; take_E = 0; target_E = 0; redirect_ready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   typedef struct {
      string           name;
      logic [PC_W-1:0] pc;
      logic [1:0]      pred;
      logic [PC_W-1:0] ptg;
      logic            br, jp, tk;
      logic [PC_W-1:0] tgt;
      logic            e_ub, e_uj, e_ut, e_redir;
      logic [PC_W-1:0] e_rpc;
      logic [15:0]     e_bcnt;
   } vec_t;

   vec_t vecs[8];

   task automatic send_to_E(input logic [PC_W-1:0] pc, input logic [1:0] pred,
                            input logic [PC_W-1:0] ptg);
      valid_F = 1; pc_F = pc; predict_F = pred; ptarget_F = ptg;
      @(posedge clk);
      @(negedge clk);
      valid_F = 0;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{"taken_ok",     8'h10, 2'b11, 8'h40, 1, 0, 1, 8'h40, 1, 0, 1, 0, 8'h00, 16'd1};
      vecs[1] = '{"dir_misp",     8'h20, 2'b01, 8'h00, 1, 0, 1, 8'h80, 1, 0, 1, 1, 8'h80, 16'd1};
      vecs[2] = '{"nt_wrap",      8'hFC, 2'b10, 8'h50, 1, 0, 0, 8'h99, 1, 0, 0, 1, 8'h00, 16'd1};
      vecs[3] = '{"jump_tgt",     8'h44, 2'b11, 8'h30, 0, 1, 0, 8'h34, 0, 1, 1, 1, 8'h34, 16'd1};
      vecs[4] = '{"br_and_jump",  8'h50, 2'b11, 8'h60, 1, 1, 0, 8'h60, 0, 1, 1, 0, 8'h00, 16'd1};
      vecs[5] = '{"nt_ok",        8'h70, 2'b00, 8'h12, 1, 0, 0, 8'h12, 1, 0, 0, 0, 8'h00, 16'd1};
      vecs[6] = '{"non_branch",   8'h80, 2'b11, 8'h90, 0, 0, 1, 8'h99, 0, 0, 1, 0, 8'h00, 16'd0};
      vecs[7] = '{"br_tgt_misp",  8'h90, 2'b11, 8'hA0, 1, 0, 1, 8'hA4, 1, 0, 1, 1, 8'hA4, 16'd1};

      idle_inputs();
      rst = 1;
      #2;
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_flush", {flush_D, flush_E}, 0);
      chk("rst_upd", {upd_branch, upd_jump}, 0);
      chk("rst_cnts", {branch_cnt, mispred_cnt}, 0);
      @(negedge clk);
      rst = 0;

      // ---------------- directed vectors ----------------
      for (int i = 0; i < 8; i++) begin
         do_reset();
         send_to_E(vecs[i].pc, vecs[i].pred, vecs[i].ptg);
         branch_E = vecs[i].br; jump_E = vecs[i].jp; take_E = vecs[i].tk; target_E = vecs[i].tgt;
         #1;
         chk({vecs[i].name, "_upd_branch"}, upd_branch, vecs[i].e_ub);
         chk({vecs[i].name, "_upd_jump"}, upd_jump, vecs[i].e_uj);
         chk({vecs[i].name, "_upd_take"}, upd_take, vecs[i].e_ut);
         chk({vecs[i].name, "_upd_pc"}, upd_pc, vecs[i].pc);
         @(posedge clk);
         @(negedge clk);
         branch_E = 0; jump_E = 0; take_E = 0;
         #1;
         chk({vecs[i].name, "_redirect_valid"}, redirect_valid, vecs[i].e_redir);
         chk({vecs[i].name, "_redirect_pc"}, redirect_pc, vecs[i].e_rpc);
         chk({vecs[i].name, "_flush"}, {flush_D, flush_E}, {2{vecs[i].e_redir}});
         chk({vecs[i].name, "_branch_cnt"}, branch_cnt, vecs[i].e_bcnt);
         chk({vecs[i].name, "_mispred_cnt"}, mispred_cnt, 32'(vecs[i].e_redir));
         if (vecs[i].e_redir) begin
            redirect_ready = 1;
            @(posedge clk);
            @(negedge clk);
            redirect_ready = 0;
            #1;
            chk({vecs[i].name, "_redirect_done"}, redirect_valid, 0);
         end
      end

      // ---------------- handshake hold ----------------
      do_reset();
      send_to_E(8'h20, 2'b01, 8'h00);
      branch_E = 1; take_E = 1; target_E = 8'h80;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         branch_E = (i == 1); take_E = 0; target_E = 8'h11;
         stall = i[0]; valid_F = 1; pc_F = 8'h33 + 8'(i); predict_F = 2'b11;
         #1;
         chk("hold_redirect_valid", redirect_valid, 1);
         chk("hold_redirect_pc", redirect_pc, 8'h80);
         chk("hold_flush", {flush_D, flush_E}, 2'b11);
         chk("hold_no_strobe", {upd_branch, upd_jump}, 0);
      end
      @(negedge clk);
      redirect_ready = 1; stall = 1; valid_F = 1; branch_E = 0;
      #1;
      chk("hold_ready_cycle", redirect_valid, 1);
      @(posedge clk);
      @(negedge clk);
      redirect_ready = 0; stall = 0; valid_F = 0; branch_E = 1; take_E = 1;
      #1;
      chk("hold_back_idle", redirect_valid, 0);
      chk("hold_E_squashed", upd_branch, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("hold_D_not_loaded", upd_branch, 0);
      chk("hold_cnt", {branch_cnt, mispred_cnt}, {16'd1, 16'd1});
      branch_E = 0; take_E = 0;

      // ---------------- reset aborts a redirect ----------------
      do_reset();
      send_to_E(8'h60, 2'b11, 8'h70);
      jump_E = 1; target_E = 8'h74;
      @(posedge clk);
      @(negedge clk);
      jump_E = 0;
      #1;
      chk("abort_pre", redirect_valid, 1);
      #2;
      rst = 1;
      #1;
      chk("abort_redirect_valid", redirect_valid, 0);
      chk("abort_flush", {flush_D, flush_E}, 0);
      chk("abort_cnt", mispred_cnt, 0);
      @(negedge clk);
      rst = 0;

      // ---------------- random traffic vs model ----------------
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         valid_F        = ($urandom_range(0, 9) < 7);
         pc_F           = 8'($urandom);
         predict_F      = 2'($urandom);
         ptarget_F      = 8'($urandom_range(0, 3) * 16);
         stall          = ($urandom_range(0, 4) == 0);
         branch_E       = $urandom_range(0, 1) == 1;
         jump_E         = ($urandom_range(0, 4) == 0);
         take_E         = $urandom_range(0, 1) == 1;
         target_E       = $urandom_range(0, 1) == 1 ? m_ptgE : 8'($urandom_range(0, 3) * 16);
         redirect_ready = $urandom_range(0, 1) == 1;
         #1;
         chk("rnd_redirect_valid", redirect_valid, m_redir);
         chk("rnd_redirect_pc", redirect_pc, m_rpc);
         chk("rnd_flush", {flush_D, flush_E}, {2{m_redir}});
         chk("rnd_upd_branch", upd_branch, m_res && branch_E && !jump_E);
         chk("rnd_upd_jump", upd_jump, m_res && jump_E);
         chk("rnd_upd_take", upd_take, jump_E ? 1'b1 : take_E);
         if (m_res) chk("rnd_upd_pc", upd_pc, m_pcE);
         chk("rnd_branch_cnt", branch_cnt, sat(m_bcnt, 65535));
         chk("rnd_mispred_cnt", mispred_cnt, sat(m_mcnt, 65535));
         chk("rnd_sat_branch_cnt", s_branch_cnt, sat(m_bcnt, 15));
         chk("rnd_sat_mispred_cnt", s_mispred_cnt, sat(m_mcnt, 15));
         chk("rnd_sat_redirect", {s_redirect_valid, s_redirect_pc}, {m_redir, m_rpc});
      end
      chk("sat_mispred_full", s_mispred_cnt, 4'hF);
      chk("sat_branch_full", s_branch_cnt, 4'hF);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
